// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract with NZCV flags; the carry chain is cut into STAGES chunks.
// Latency STAGES cycles, one op per clock; optional signed saturation when ADDSUB_SAT_EN is defined.
// Backpressure: one global advance (!out_valid || out_ready) drives in_ready; when it is low every stage holds.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v,
    output logic             sat
);

    localparam int CW = WIDTH / STAGES;
    localparam int NP = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int F  = STAGES - 1;

    logic                w_en;

    // Per-stage inputs. Operands are pre-shifted so the active chunk always sits in [CW-1:0];
    // finished sum chunks enter at the top of the sum word and shift down, ending in place.
    logic                w_vld [STAGES];
    logic [WIDTH-1:0]    w_a   [STAGES];
    logic [WIDTH-1:0]    w_b   [STAGES];
    logic [WIDTH-1:0]    w_s   [STAGES];
    logic                w_ci  [STAGES];
    logic [CW:0]         w_t   [STAGES];
    logic [CW+WIDTH-1:0] w_cat [STAGES];
    logic [WIDTH-1:0]    w_ns  [STAGES];

    logic                r_vld [NP];
    logic [WIDTH-1:0]    r_a   [NP];
    logic [WIDTH-1:0]    r_b   [NP];
    logic [WIDTH-1:0]    r_s   [NP];
    logic                r_c   [NP];

    logic [WIDTH-1:0]    w_raw;
    logic [WIDTH-1:0]    w_res;
    logic                w_cout;
    logic                w_cmsb;
    logic                w_ovf;

    logic                r_out_vld;
    logic [WIDTH-1:0]    r_sum;
    logic                r_n;
    logic                r_z;
    logic                r_cf;
    logic                r_v;

    assign w_en     = !r_out_vld || out_ready;
    assign in_ready = w_en;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                w_vld[k] = in_valid;
                w_a[k]   = a;
                w_b[k]   = op ? ~b : b;
                w_s[k]   = '0;
                w_ci[k]  = cin;
            end else begin
                w_vld[k] = r_vld[k-1];
                w_a[k]   = r_a[k-1];
                w_b[k]   = r_b[k-1];
                w_s[k]   = r_s[k-1];
                w_ci[k]  = r_c[k-1];
            end
            w_t[k]   = {1'b0, w_a[k][CW-1:0]} + {1'b0, w_b[k][CW-1:0]} + {{CW{1'b0}}, w_ci[k]};
            w_cat[k] = {w_t[k][CW-1:0], w_s[k]};
            w_ns[k]  = w_cat[k][CW +: WIDTH];
        end
    end

    // In the last stage bit CW-1 of the shifted operands is the true MSB of a and b'.
    assign w_raw  = w_ns[F];
    assign w_cout = w_t[F][CW];
    assign w_cmsb = w_t[F][CW-1] ^ w_a[F][CW-1] ^ w_b[F][CW-1];
    assign w_ovf  = w_cmsb ^ w_cout;

`ifdef ADDSUB_SAT_EN
    logic r_sat;

    always_comb begin
        w_res = w_raw;
        if (w_ovf) begin
            w_res = w_a[F][CW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat <= 1'b0;
        end else if (w_en && w_vld[F]) begin
            r_sat <= w_ovf;
        end
    end

    assign sat = r_sat;
`else
    assign w_res = w_raw;
    assign sat   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NP; k++) begin
                r_vld[k] <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_s[k]   <= '0;
                r_c[k]   <= 1'b0;
            end
        end else if (w_en) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                r_vld[k] <= w_vld[k];
                r_a[k]   <= w_a[k] >> CW;
                r_b[k]   <= w_b[k] >> CW;
                r_s[k]   <= w_ns[k];
                r_c[k]   <= w_t[k][CW];
            end
        end
    end

    // Result and flags only load on a real token so they keep their last value across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_sum     <= '0;
            r_n       <= 1'b0;
            r_z       <= 1'b0;
            r_cf      <= 1'b0;
            r_v       <= 1'b0;
        end else if (w_en) begin
            r_out_vld <= w_vld[F];
            if (w_vld[F]) begin
                r_sum <= w_res;
                r_n   <= w_res[WIDTH-1];
                r_z   <= (w_res == '0);
                r_cf  <= w_cout;
                r_v   <= w_ovf;
            end
        end
    end

    assign out_valid = r_out_vld;
    assign sum       = r_sum;
    assign n         = r_n;
    assign z         = r_z;
    assign c         = r_cf;
    assign v         = r_v;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub (WIDTH=32, STAGES=4) with a result scoreboard.
module tb_pipelined_addsub;

    localparam int W  = 32;
    localparam int ST = 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         n;
        logic         z;
        logic         c;
        logic         v;
        logic         sat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         n;
    logic         z;
    logic         c;
    logic         v;
    logic         sat;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   out_cnt;
    int   first_in_cyc;
    int   first_out_cyc;
    int   last_out_cyc;
    logic last_acc_in;

    pipelined_addsub #(.WIDTH(W), .STAGES(ST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .n         (n),
        .z         (z),
        .c         (c),
        .v         (v),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic icin, input logic iop);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic [W-1:0] low;
        bb   = iop ? ~ib : ib;
        full = {1'b0, ia} + {1'b0, bb} + {{W{1'b0}}, icin};
        low  = {1'b0, ia[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, icin};
        e.s   = full[W-1:0];
        e.c   = full[W];
        e.v   = low[W-1] ^ full[W];
        e.sat = 1'b0;
`ifdef ADDSUB_SAT_EN
        if (e.v) begin
            e.s   = ia[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            e.sat = 1'b1;
        end
`endif
        e.n = e.s[W-1];
        e.z = (e.s == '0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic clr_stats();
        out_cnt       = 0;
        first_in_cyc  = -1;
        first_out_cyc = -1;
        last_out_cyc  = -1;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        logic        acc_in;
        logic        acc_out;
        logic        hold;
        logic [37:0] snap;
        exp_t        e;
        #1;
        acc_in  = in_valid && in_ready;
        acc_out = out_valid && out_ready;
        hold    = out_valid && !out_ready;
        snap    = {out_valid, sum, n, z, c, v, sat};
        if (hold) check("in_ready_during_stall", {63'b0, in_ready}, 64'd0);
        if (acc_out) begin
            if (sb.size() == 0) begin
                check("spurious_output", {63'b0, out_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("sum", {32'b0, sum}, {32'b0, e.s});
                check("flags_nzcv_sat", {59'b0, n, z, c, v, sat}, {59'b0, e.n, e.z, e.c, e.v, e.sat});
                out_cnt++;
                if (first_out_cyc < 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
            end
        end
        if (acc_in) begin
            sb.push_back(model(a, b, cin, op));
            if (first_in_cyc < 0) first_in_cyc = cyc;
        end
        last_acc_in = acc_in;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (hold) check("output_hold_stable", {26'b0, out_valid, sum, n, z, c, v, sat}, {26'b0, snap});
    endtask

    task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic icin, input logic iop);
        a        = ia;
        b        = ib;
        cin      = icin;
        op       = iop;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        check("drained_queue_size", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        op        = 1'b0;
        out_ready = 1'b0;
        clr_stats();

        // Reset values; in_ready must come from !out_valid with out_ready low.
        @(negedge clk);
        #1;
        check("reset_out_valid", {63'b0, out_valid}, 64'd0);
        check("reset_outputs", {27'b0, sum, n, z, c, v, sat}, 64'd0);
        check("reset_in_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        // Carry crossing a chunk boundary, plus latency.
        send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        for (int i = 1; i < ST; i++) begin
            check("latency_not_yet_valid", {63'b0, out_valid}, 64'd0);
            tick();
        end
        check("latency_valid", {63'b0, out_valid}, 64'd1);
        check("chunk_carry_sum", {32'b0, sum}, 64'h0001_0000);
        check("chunk_carry_nzcv", {60'b0, n, z, c, v}, 64'd0);
        drain();

        // Subtract / flag patterns, issued back to back.
        send(32'd5, 32'd5, 1'b1, 1'b1);
        send(32'd3, 32'd5, 1'b1, 1'b1);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
        drain();

        // Full-throughput stream.
        clr_stats();
        for (int i = 0; i < 8; i++) begin
            a        = 32'(i);
            b        = 32'(i);
            cin      = 1'b0;
            op       = 1'b0;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        drain();
        check("stream_count", 64'(out_cnt), 64'd8);
        check("stream_first_latency", 64'(first_out_cyc - first_in_cyc), 64'(ST));
        check("stream_no_gaps", 64'(last_out_cyc - first_out_cyc), 64'd7);

        // Same stream with a downstream stall in cycles 6..9.
        clr_stats();
        begin
            int sent;
            sent = 0;
            for (int t = 0; t < 60 && (sent < 8 || sb.size() != 0); t++) begin
                out_ready = !(t >= 6 && t <= 9);
                in_valid  = (sent < 8);
                a         = 32'(sent);
                b         = 32'(sent);
                tick();
                if (last_acc_in) sent++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            check("stall_all_sent", 64'(sent), 64'd8);
        end
        check("stall_count", 64'(out_cnt), 64'd8);
        check("stall_queue_empty", 64'(sb.size()), 64'd0);

        // Reset with tokens in flight and one held at the output.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'(100 + i), 32'(200 + i), 1'b1, 1'b0);
        check("pre_reset_valid", {63'b0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", {63'b0, out_valid}, 64'd0);
        check("async_reset_outputs", {27'b0, sum, n, z, c, v, sat}, 64'd0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        clr_stats();
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        check("post_reset_single_token", 64'(out_cnt), 64'd1);
        check("post_reset_latency", 64'(first_out_cyc - first_in_cyc), 64'(ST));
        check("final_queue_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
